crc16_frame_check: RTL
======================

# crc16_frame_check

Receive-side command frame checker for the tag. It takes the demodulated forward-link bit stream, one bit per enabled `crcinclk` edge. It decodes the 8-bit command code, tracks the expected frame length for that command and runs a CRC-16 (CCITT, x^16+x^12+x^5+1, preset FFFF) over every bit including the trailing CRC. On the last bit it reports pass or fail against the residue 16'h1D0F. It sits between the bit demodulator and the command execution logic; results gate ReqRN/Read/Write (and optionally SensData) execution.

## Interface
- No parameters; all lengths and codes are fixed constants.
- `crcinclk`  in  1  bit clock; may be free-running; only edges with `bitvalid`=1 advance the block.
- `reset`  in  1  asynchronous, active-high.
- `framestart`  in  1  synchronous frame restart, sampled on `crcinclk`.
- `bitvalid`  in  1  `bitin` is valid this edge.
- `bitin`  in  1  forward-link bit, MSB first.
- `framedone`  out  1  high from the final-bit edge until the next `framestart`/`reset`.
- `crcok`  out  1  CRC residue matched; valid while `framedone`=1.
- `cmderr`  out  1  unknown or unsupported command; sticky until `framestart`/`reset`.
- `cmdcode`  out  8  captured command code.
- `bitcount`  out  7  bits absorbed in the current frame.

## Operation
- States: IDLE, HEADER, BODY, DONE, ERROR.
- **IDLE:** entered after reset. Bits are ignored until `framestart`.
- **`framestart`:** forces LFSR=FFFF, `bitcount`=0, `cmdcode`=0, and clears all flags. The state becomes HEADER.
- **`framestart` with `bitvalid` on the same edge:** that bit is bit 0 of the new frame, and the LFSR update uses FFFF.
- **Every accepted bit in HEADER/BODY:** LFSR absorbs `bitin`, and `bitcount` increments.
- **HEADER:** shifts bits into `cmdcode`. After bit 8, the code is decoded:
  - C1 ReqRN: total length 40.
  - C2 Read: total length 58 (8 code, 2 membank, 8 EBV, 8 wordcount, 16 RN, 16 CRC).
  - C3 Write: total length 66 (8, 2, 8 EBV, 16 data, 16 RN, 16 CRC).
  - Any other code: ERROR with `cmderr`=1.
- **BODY, Read/Write only:** the bit at index 10 is the EBV extension flag. A value of 1 goes to ERROR with `cmderr`=1 (multi-byte EBV is unsupported).
- **Final bit** (`bitcount` reaching the total length on this edge):
  - `framedone`<=1.
  - `crcok`<=(next LFSR value == 16'h1D0F).
  - The state goes to DONE.
- **DONE/ERROR:** further bits are ignored and all outputs hold. Only `framestart` or `reset` exits.
- **ERROR:** `framedone` stays 0 and `crcok` stays 0.
- **Bit overflow:** `bitcount` saturates and never wraps; the maximum length is 66 and the counter is 7 bits.

## Timing
- Reset values: `framedone`=0, `crcok`=0, `cmderr`=0, `cmdcode`=8'h00, `bitcount`=0, LFSR=FFFF, state IDLE.
- Zero extra clocks: the result is registered on the same edge that absorbs the final bit, with no flush pulse needed.
- `cmderr` is registered on the edge absorbing bit 8, or bit 10 for an EBV error.
- Edges with `bitvalid`=0 and `framestart`=0 change nothing.
- Reset mid-frame: all state returns to reset values immediately (asynchronous); no partial result is reported.
- `framestart` mid-frame: the current frame is discarded silently and the new frame starts on that edge.

## Configuration
- Macro `CRC16_FRAME_CHECK_SENSDATA_EN`.
- Defined: code E1 (SensData) is accepted with total length 48 (8 code, 8 sensor select, 16 RN, 16 CRC).
- Undefined: E1 is treated as unknown, giving ERROR with `cmderr`=1.

## Structure
- Shared package holds:
  - command code constants (C1, C2, C3, E1);
  - total-length constants (40, 58, 66, 48);
  - the residue constant 16'h1D0F;
  - the preset 16'hFFFF;
  - the state enum.
- One sub-module, `crc16_lfsr`:
  - inputs: synchronous clear-to-FFFF, enable, bit in;
  - outputs: current and next-state 16-bit value (the checker compares the next state).
- The FSM, length decode and counters live in the top module.

## Test plan
- ReqRN C1, RN=16'h1234, correct CRC appended -> on the 40th bit: `framedone`=1, `crcok`=1, `cmdcode`=C1, `bitcount`=40.
- Same frame with bit 20 inverted -> `framedone`=1, `crcok`=0 on the 40th bit.
- Read C2, membank 2'b11, EBV 8'h05, count 8'h02, valid CRC, with random `bitvalid`=0 gaps -> `crcok`=1 after exactly 58 accepted bits; gap edges change nothing.
- Code 8'hAA -> `cmderr`=1 on bit 8; 50 further bits ignored, `framedone`=0; `framestart` clears `cmderr`.
- Write C3 with EBV first bit=1 -> `cmderr`=1 on bit 10. Separately, assert `reset` at bit 30 of a valid Write -> all outputs 0 and state IDLE.
- E1 frame, valid CRC, 48 bits -> `crcok`=1 with the macro defined; `cmderr`=1 at bit 8 without it. Also `framestart`+`bitvalid` on the same edge -> that bit is counted as bit 0.

Source files
------------

// File: rtl/crc16_frame_check_pkg.sv
// Shared constants, state encoding and command-length decode for the forward-link CRC-16 checker.
// The SensData command is only recognised when CRC16_FRAME_CHECK_SENSDATA_EN is defined.
package crc16_frame_check_pkg;

    localparam logic [7:0] CmdReqRn    = 8'hC1;
    localparam logic [7:0] CmdRead     = 8'hC2;
    localparam logic [7:0] CmdWrite    = 8'hC3;
    localparam logic [7:0] CmdSensData = 8'hE1;

    localparam logic [6:0] LenReqRn    = 7'd40;
    localparam logic [6:0] LenRead     = 7'd58;
    localparam logic [6:0] LenWrite    = 7'd66;
    localparam logic [6:0] LenSensData = 7'd48;

    localparam logic [6:0] HdrBits    = 7'd8;
    localparam logic [6:0] EbvFlagIdx = 7'd10;

    localparam logic [15:0] CrcPreset  = 16'hFFFF;
    localparam logic [15:0] CrcResidue = 16'h1D0F;
    localparam logic [15:0] CrcPoly    = 16'h1021;

`ifdef CRC16_FRAME_CHECK_SENSDATA_EN
    localparam bit SensDataEn = 1'b1;
`else
    localparam bit SensDataEn = 1'b0;
`endif

    typedef enum logic [2:0] {
        StIdle,
        StHeader,
        StBody,
        StDone,
        StError
    } state_e;

    // Zero means the code is unknown or not supported in this build.
    function automatic logic [6:0] frame_len(input logic [7:0] code);
        logic [6:0] len;
        len = '0;
        case (code)
            CmdReqRn:    len = LenReqRn;
            CmdRead:     len = LenRead;
            CmdWrite:    len = LenWrite;
            CmdSensData: len = SensDataEn ? LenSensData : '0;
            default:     len = '0;
        endcase
        return len;
    endfunction

    function automatic logic has_ebv(input logic [7:0] code);
        return (code == CmdRead) || (code == CmdWrite);
    endfunction

endpackage

// File: rtl/crc16_frame_check_if.sv
// Bit-stream input and frame-result output bundle between the demodulator and the frame checker.
interface crc16_frame_check_if;

    logic       framestart;
    logic       bitvalid;
    logic       bitin;
    logic       framedone;
    logic       crcok;
    logic       cmderr;
    logic [7:0] cmdcode;
    logic [6:0] bitcount;

    modport master (
        output framestart,
        output bitvalid,
        output bitin,
        input  framedone,
        input  crcok,
        input  cmderr,
        input  cmdcode,
        input  bitcount
    );

    modport slave (
        input  framestart,
        input  bitvalid,
        input  bitin,
        output framedone,
        output crcok,
        output cmderr,
        output cmdcode,
        output bitcount
    );

endinterface

// File: rtl/crc16_frame_check_lfsr.sv
// Serial MSB-first CRC-16/CCITT register with a synchronous preset that can coincide with a shift.
module crc16_lfsr
    import crc16_frame_check_pkg::*;
(
    input  logic        crcinclk,
    input  logic        reset,
    input  logic        clear,
    input  logic        enable,
    input  logic        din,
    output logic [15:0] crc,
    output logic [15:0] crc_next
);

    logic [15:0] crc_q;
    logic [15:0] base;
    logic        feedback;

    // A clear on the same edge as a shift absorbs the bit into the preset value.
    always_comb begin
        base     = clear ? CrcPreset : crc_q;
        feedback = base[15] ^ din;
        crc_next = {base[14:0], 1'b0} ^ (feedback ? CrcPoly : 16'h0000);
    end

    always_ff @(posedge crcinclk or posedge reset) begin
        if (reset) begin
            crc_q <= CrcPreset;
        end else if (enable) begin
            crc_q <= crc_next;
        end else if (clear) begin
            crc_q <= CrcPreset;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/crc16_frame_check.sv
// Forward-link command frame checker: decodes the command, tracks frame length, checks CRC-16.
// Define CRC16_FRAME_CHECK_SENSDATA_EN to accept the E1 SensData command.
module crc16_frame_check
    import crc16_frame_check_pkg::*;
(
    input  logic                 crcinclk,
    input  logic                 reset,
    crc16_frame_check_if.slave   bus
);

    state_e      state_q, state_d;
    logic [6:0]  count_q, count_d;
    logic [7:0]  code_q, code_d;
    logic        done_q, done_d;
    logic        ok_q, ok_d;
    logic        err_q, err_d;

    logic        lfsr_clear;
    logic        lfsr_en;
    logic [15:0] crc_cur;
    logic [15:0] crc_next;
    logic [6:0]  count_inc;
    logic [7:0]  hdr_code;

    crc16_lfsr u_lfsr (
        .crcinclk (crcinclk),
        .reset    (reset),
        .clear    (lfsr_clear),
        .enable   (lfsr_en),
        .din      (bus.bitin),
        .crc      (crc_cur),
        .crc_next (crc_next)
    );

    assign count_inc = (count_q == 7'h7F) ? count_q : count_q + 7'd1;
    assign hdr_code  = {code_q[6:0], bus.bitin};

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        code_d     = code_q;
        done_d     = done_q;
        ok_d       = ok_q;
        err_d      = err_q;
        lfsr_clear = 1'b0;
        lfsr_en    = 1'b0;

        if (bus.framestart) begin
            lfsr_clear = 1'b1;
            state_d    = StHeader;
            count_d    = '0;
            code_d     = '0;
            done_d     = 1'b0;
            ok_d       = 1'b0;
            err_d      = 1'b0;
            if (bus.bitvalid) begin
                lfsr_en = 1'b1;
                count_d = 7'd1;
                code_d  = {7'b0, bus.bitin};
            end
        end else if (bus.bitvalid) begin
            unique case (state_q)
                StHeader: begin
                    lfsr_en = 1'b1;
                    count_d = count_inc;
                    code_d  = hdr_code;
                    if (count_inc == HdrBits) begin
                        if (frame_len(hdr_code) == '0) begin
                            state_d = StError;
                            err_d   = 1'b1;
                        end else begin
                            state_d = StBody;
                        end
                    end
                end
                StBody: begin
                    lfsr_en = 1'b1;
                    count_d = count_inc;
                    // Multi-byte EBV is not supported: its extension flag must be 0.
                    if (has_ebv(code_q) && (count_q == EbvFlagIdx) && bus.bitin) begin
                        state_d = StError;
                        err_d   = 1'b1;
                    end else if (count_inc == frame_len(code_q)) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                        ok_d    = (crc_next == CrcResidue);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge crcinclk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            count_q <= '0;
            code_q  <= '0;
            done_q  <= 1'b0;
            ok_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            code_q  <= code_d;
            done_q  <= done_d;
            ok_q    <= ok_d;
            err_q   <= err_d;
        end
    end

    assign bus.framedone = done_q;
    assign bus.crcok     = ok_q;
    assign bus.cmderr    = err_q;
    assign bus.cmdcode   = code_q;
    assign bus.bitcount  = count_q;

    // A reported pass must leave the register parked on the residue.
    ok_holds_residue: assert property (@(posedge crcinclk) disable iff (reset)
        (state_q == StDone && ok_q) |-> (crc_cur == CrcResidue));

endmodule
